pwm_ramp_controller: RTL and testbench
======================================

Name: pwm_ramp_controller

Overview:
Autonomous duty-cycle sequencer placed between the SPI register bank and the PWM peripheral. When given a target duty, step size and step interval, it takes over the PWM duty register and ramps it from the current SPI-written value to the target. At the target it holds the value until released, then returns control to the SPI register.

Parameters:
DUTY_W, 8, width of duty-cycle values (matches the PWM peripheral duty register).
INTERVAL_W, 16, width of the step-interval counter (clk cycles).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
cfg_valid  input  1  a ramp request is presented.
cfg_ready  output  1  the controller can accept a request; high in IDLE and HOLD.
cfg_target  input  DUTY_W  final duty value.
cfg_step  input  DUTY_W  increment per step; 0 is treated as 1.
cfg_interval  input  INTERVAL_W  a step occurs every cfg_interval+1 cycles.
abort  input  1  abandon the ramp or hold and return to IDLE.
release  input  1  leave HOLD and return duty control to SPI.
duty_in  input  DUTY_W  current SPI duty register value.
duty_out  output  DUTY_W  duty value driven to the PWM peripheral when override is high.
duty_override  output  1  1 = PWM peripheral uses duty_out; 0 = it uses duty_in.
busy  output  1  high in RAMP.
done  output  1  one-cycle pulse when the target is reached.

Behaviour:
- Reset values (asynchronous): state=IDLE, duty_out=0, duty_override=0, busy=0, done=0, prescale counter=0. All registers update on the clk rising edge.
- States: IDLE, RAMP, HOLD.
- Handshake: a request is accepted on an edge where cfg_valid && cfg_ready.
  - At acceptance, latch target, step (0 becomes 1) and interval. Load duty_out<=duty_in and cnt<=interval.
  - The next state is RAMP, with duty_override=1 and busy=1.
- RAMP, evaluated each edge in this priority order:
  - If abort: go to IDLE, override<=0, busy<=0, done stays 0.
  - Else if duty_out==target: go to HOLD, busy<=0, done<=1 for exactly one cycle.
  - Else if cnt==0: apply one step, cnt<=interval.
  - Else: cnt<=cnt-1.
- Timing:
  - The first step lands on edge N+interval+1, where N is the acceptance edge. Steps are spaced interval+1 cycles apart.
  - If duty_in==target at acceptance, the controller enters HOLD on edge N+1.
- Step arithmetic:
  - Computed with DUTY_W+1 bits; no wrap-around and no overshoot.
  - Up (target>duty): if target-duty<=step then duty<=target, else duty<=duty+step.
  - Down (target<duty): if duty-target<=step then duty<=target, else duty<=duty-step.
- HOLD:
  - duty_out=target and override=1.
  - cfg_valid takes priority: the new request is accepted and ramps from the current duty_out, not from duty_in.
  - Otherwise, release or abort goes to IDLE with override<=0.
- IDLE: override=0 and duty_out keeps its last value. abort and release are ignored.
- Simultaneous events:
  - abort beats cfg_valid in every state.
  - In HOLD, cfg_valid beats release.
  - cfg_valid in RAMP is not accepted (cfg_ready=0); the requester must hold it.
- Reset mid-ramp: immediate return to reset values. duty_override drops asynchronously, so the PWM reverts to the SPI duty.
- done never coincides with busy=1.

Decomposition:
- Shared package pwm_ctrl_pkg contains:
  - the state enum {IDLE, RAMP, HOLD};
  - the default DUTY_W and INTERVAL_W constants;
  - a step-saturate function (cur, tgt, step) -> next.
- One sub-module, ramp_tick_gen: a loadable down-counter with inputs load, load_val and run, and a one-cycle tick output when it reaches 0 while run is high. It reloads on tick.

Test Plan:
- Up-ramp: duty_in=10, target=50, step=10, interval=3 -> duty_out 10, 20, 30, 40, 50 with changes 4 cycles apart; done pulses once on the edge after 50 appears; override stays 1 in HOLD.
- Saturation down: duty_in=200, target=5, step=64, interval=0 -> duty_out 200, 136, 72, 8, 5 on consecutive cycles; no wrap below 5.
- Boundary cases:
  - step=0, target=3 from 0 -> behaves as step=1 (0, 1, 2, 3).
  - duty_in==target=77 -> HOLD and done one cycle after acceptance.
- Abort mid-ramp at duty_out=30 -> next edge state=IDLE, override=0, done never asserted; a simultaneous cfg_valid is not accepted.
- HOLD at 50, then new cfg (target=20, step=15) together with release -> release ignored; ramp 50, 35, 20 from the held value. Then release alone -> override=0 the next cycle.
- Assert rst mid-ramp (duty_out=90) -> duty_override, busy and duty_out go to 0 without a clock edge; after deassert, cfg_ready=1.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared state encoding, default widths and saturating step helper
package pwm_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;
  localparam int DEF_DUTY_W = 8;
  localparam int DEF_INTERVAL_W = 16;
  function automatic int unsigned step_sat(int unsigned cur, int unsigned tgt, int unsigned stp);
    return tgt > cur ? ((tgt - cur <= stp) ? tgt : cur + stp)
                     : ((cur - tgt <= stp) ? tgt : cur - stp);
  endfunction
endpackage

// File: rtl/ramp_tick_gen.sv
// ramp_tick_gen: loadable down-counter emitting a one-cycle tick at zero while running (ports: clk, rst, load, load_val, run -> tick)
module ramp_tick_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         tick
);
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_reload;
  assign tick = run && r_cnt == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_reload <= '0;
    end else if (load) begin
      r_cnt    <= load_val;
      r_reload <= load_val;
    end else if (tick) r_cnt <= r_reload;
    else if (run) r_cnt <= r_cnt - 1'b1;
  end
endmodule

// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller: ramps PWM duty from the SPI value to a target, holds it, then hands control back (ports: clk, rst, cfg_* handshake, abort, release_req, duty_in -> duty_out, duty_override, busy, done)
module pwm_ramp_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W     = DEF_DUTY_W,
  parameter int INTERVAL_W = DEF_INTERVAL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DUTY_W-1:0]     cfg_target,
  input  logic [DUTY_W-1:0]     cfg_step,
  input  logic [INTERVAL_W-1:0] cfg_interval,
  input  logic                  abort,
  input  logic                  release_req,
  input  logic [DUTY_W-1:0]     duty_in,
  output logic [DUTY_W-1:0]     duty_out,
  output logic                  duty_override,
  output logic                  busy,
  output logic                  done
);
  state_t            r_state;
  state_t            w_next;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_target;
  logic [DUTY_W-1:0] r_step;
  logic              r_done;
  logic              w_accept;
  logic              w_at_tgt;
  logic              w_run;
  logic              w_tick;
  assign cfg_ready     = r_state != RAMP;
  assign w_accept      = cfg_valid && cfg_ready && !abort;
  assign w_at_tgt      = r_duty == r_target;
  assign w_run         = r_state == RAMP && !abort && !w_at_tgt;
  // outputs decode straight from state so the async reset drops override without a clock edge
  assign duty_override = r_state != IDLE;
  assign busy          = r_state == RAMP;
  assign duty_out      = r_duty;
  assign done          = r_done;
  ramp_tick_gen #(.W(INTERVAL_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (w_accept),
    .load_val (cfg_interval),
    .run      (w_run),
    .tick     (w_tick)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? RAMP : IDLE;
      RAMP:    w_next = abort ? IDLE : w_at_tgt ? HOLD : RAMP;
      HOLD:    w_next = abort ? IDLE : w_accept ? RAMP : release_req ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_duty   <= '0;
      r_target <= '0;
      r_step   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == RAMP && !abort && w_at_tgt;
      if (w_accept) begin
        r_target <= cfg_target;
        r_step   <= cfg_step == '0 ? DUTY_W'(1) : cfg_step;
        // a re-request from HOLD continues from the held value, not the SPI register
        r_duty   <= r_state == HOLD ? r_duty : duty_in;
      end else if (w_tick) r_duty <= DUTY_W'(step_sat(32'(r_duty), 32'(r_target), 32'(r_step)));
    end
  end
endmodule

// File: tb/tb_pwm_ramp_controller.sv
// tb_pwm_ramp_controller: directed checks of ramp timing, saturation, abort, hold re-request and async reset
module tb_pwm_ramp_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_target;
  logic [7:0]  cfg_step;
  logic [15:0] cfg_interval;
  logic        abort;
  logic        release_req;
  logic [7:0]  duty_in;
  logic [7:0]  duty_out;
  logic        duty_override;
  logic        busy;
  logic        done;
  int          total = 0;
  int          bad = 0;
  pwm_ramp_controller dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_target    (cfg_target),
    .cfg_step      (cfg_step),
    .cfg_interval  (cfg_interval),
    .abort         (abort),
    .release_req   (release_req),
    .duty_in       (duty_in),
    .duty_out      (duty_out),
    .duty_override (duty_override),
    .busy          (busy),
    .done          (done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic req(input int tgt, input int stp, input int iv, input int din);
    cfg_target   = 8'(tgt);
    cfg_step     = 8'(stp);
    cfg_interval = 16'(iv);
    duty_in      = 8'(din);
    cfg_valid    = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask
  task automatic rel();
    release_req = 1'b1;
    @(negedge clk);
    release_req = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int dn[4] = '{136, 72, 8, 5};
    rst = 1'b1; cfg_valid = 1'b0; cfg_target = '0; cfg_step = '0; cfg_interval = '0;
    abort = 1'b0; release_req = 1'b0; duty_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ovr", 32'(duty_override), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_duty", 32'(duty_out), 0);
    chk("rst_rdy", 32'(cfg_ready), 1);
    rst = 1'b0;
    req(50, 10, 3, 10);
    chk("up_acc_duty", 32'(duty_out), 10);
    chk("up_acc_busy", 32'(busy), 1);
    chk("up_acc_ovr", 32'(duty_override), 1);
    chk("up_acc_rdy", 32'(cfg_ready), 0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("up_duty", 32'(duty_out), 32'(10 + 10 * (i / 4)));
      chk("up_done_low", 32'(done), 0);
    end
    @(negedge clk);
    chk("up_done", 32'(done), 1);
    chk("up_hold_busy", 32'(busy), 0);
    chk("up_hold_ovr", 32'(duty_override), 1);
    chk("up_hold_duty", 32'(duty_out), 50);
    chk("up_hold_rdy", 32'(cfg_ready), 1);
    @(negedge clk);
    chk("up_done_once", 32'(done), 0);
    chk("up_hold_ovr2", 32'(duty_override), 1);
    rel();
    chk("rel_ovr", 32'(duty_override), 0);
    chk("rel_rdy", 32'(cfg_ready), 1);
    chk("rel_duty_kept", 32'(duty_out), 50);
    req(5, 64, 0, 200);
    chk("dn_acc", 32'(duty_out), 200);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dn_duty", 32'(duty_out), 32'(dn[i]));
    end
    @(negedge clk);
    chk("dn_done", 32'(done), 1);
    chk("dn_floor", 32'(duty_out), 5);
    rel();
    chk("dn_rel_ovr", 32'(duty_override), 0);
    req(3, 0, 0, 0);
    chk("s0_acc", 32'(duty_out), 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("s0_duty", 32'(duty_out), 32'(i));
    end
    @(negedge clk);
    chk("s0_done", 32'(done), 1);
    rel();
    req(77, 5, 2, 77);
    chk("eq_acc_duty", 32'(duty_out), 77);
    chk("eq_acc_busy", 32'(busy), 1);
    chk("eq_acc_done", 32'(done), 0);
    @(negedge clk);
    chk("eq_done", 32'(done), 1);
    chk("eq_busy", 32'(busy), 0);
    chk("eq_ovr", 32'(duty_override), 1);
    chk("eq_duty", 32'(duty_out), 77);
    rel();
    req(100, 10, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("ab_duty", 32'(duty_out), 32'(10 * i));
    end
    abort = 1'b1; cfg_valid = 1'b1; cfg_target = 8'd9; duty_in = 8'd1;
    @(negedge clk);
    abort = 1'b0; cfg_valid = 1'b0;
    chk("ab_ovr", 32'(duty_override), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_duty", 32'(duty_out), 30);
    chk("ab_rdy", 32'(cfg_ready), 1);
    @(negedge clk);
    chk("ab_idle_busy", 32'(busy), 0);
    chk("ab_idle_done", 32'(done), 0);
    chk("ab_idle_duty", 32'(duty_out), 30);
    req(50, 10, 0, 40);
    @(negedge clk);
    chk("hr_duty", 32'(duty_out), 50);
    @(negedge clk);
    chk("hr_done", 32'(done), 1);
    cfg_target = 8'd20; cfg_step = 8'd15; cfg_interval = '0; duty_in = 8'd99;
    cfg_valid = 1'b1; release_req = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; release_req = 1'b0;
    chk("hr_acc_ovr", 32'(duty_override), 1);
    chk("hr_acc_busy", 32'(busy), 1);
    chk("hr_acc_duty", 32'(duty_out), 50);
    @(negedge clk);
    chk("hr_duty35", 32'(duty_out), 35);
    @(negedge clk);
    chk("hr_duty20", 32'(duty_out), 20);
    @(negedge clk);
    chk("hr_done2", 32'(done), 1);
    rel();
    chk("hr_rel_ovr", 32'(duty_override), 0);
    req(200, 10, 0, 80);
    @(negedge clk);
    chk("rr_duty", 32'(duty_out), 90);
    #2 rst = 1'b1;
    #1;
    chk("rr_ovr", 32'(duty_override), 0);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_duty0", 32'(duty_out), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rr_rdy", 32'(cfg_ready), 1);
    chk("rr_idle_busy", 32'(busy), 0);
    chk("rr_idle_ovr", 32'(duty_override), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
